// File: rtl/plat_link_pkg.sv
// Shared types, widths and helpers for the platform link and overlap checks.
// Also holds the gadget effect codes used by the gadget generator.
package plat_link_pkg;

  localparam int PIXELX_BIT_CNT        = 10;
  localparam int PIXELY_BIT_CNT        = 10;
  localparam int PLAT_HF_WIDTH_BIT_CNT = 6;
  localparam int GADGET_BIT_CNT        = 3;
  localparam int COORD_W               = 10;

  localparam logic [GADGET_BIT_CNT-1:0] GADGET_NONE   = 3'd0;
  localparam logic [GADGET_BIT_CNT-1:0] GADGET_EXPAND = 3'd1;
  localparam logic [GADGET_BIT_CNT-1:0] GADGET_SHRINK = 3'd2;
  localparam logic [GADGET_BIT_CNT-1:0] GADGET_FAST   = 3'd3;
  localparam logic [GADGET_BIT_CNT-1:0] GADGET_SLOW   = 3'd4;

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_REQ     = 3'd1,
    ST_CHECK   = 3'd2,
    ST_DELIVER = 3'd3,
    ST_DONE    = 3'd4
  } plat_link_state_e;

  // Operands are one bit wider than coordinates, so additions cannot wrap.
  function automatic logic span_overlap(input logic [COORD_W:0] g,
                                        input logic [COORD_W:0] p,
                                        input logic [COORD_W:0] reach);
    return ((g + reach) >= p) && (g <= (p + reach));
  endfunction

endpackage

// File: rtl/plat_overlap_chk.sv
// Purely combinational X/Y overlap test of an object against the platform.
// Intended for reuse by ball-versus-platform checks as well.
module plat_overlap_chk
  import plat_link_pkg::*;
#(
  parameter int GADGET_HF     = 8,
  parameter int PLAT_HF_THICK = 4
) (
  input  logic [PIXELX_BIT_CNT-1:0]        gx,
  input  logic [PIXELY_BIT_CNT-1:0]        gy,
  input  logic [PIXELX_BIT_CNT-1:0]        px,
  input  logic [PIXELY_BIT_CNT-1:0]        py,
  input  logic [PLAT_HF_WIDTH_BIT_CNT-1:0] size,
  output logic                             x_hit,
  output logic                             y_hit
);

  localparam int EW = COORD_W + 1;

  logic [COORD_W:0] x_reach_s;
  logic [COORD_W:0] y_reach_s;

  // Reach on each axis is the sum of both half-extents.
  always_comb begin
    x_reach_s = EW'(GADGET_HF) + EW'(size);
    y_reach_s = EW'(GADGET_HF + PLAT_HF_THICK);
    x_hit     = span_overlap(EW'(gx), EW'(px), x_reach_s);
    y_hit     = span_overlap(EW'(gy), EW'(py), y_reach_s);
  end

endmodule

// File: rtl/plat_link_initiator.sv
// Initiator end of the platform req/ack link: fetches platform geometry each
// frame, then delivers or reports the falling gadget against it.
module plat_link_initiator
  import plat_link_pkg::*;
#(
  parameter int ACK_TIMEOUT   = 16,
  parameter int GADGET_HF     = 8,
  parameter int PLAT_HF_THICK = 4,
  parameter int SCREEN_H      = 480
) (
  input  logic                             clk,
  input  logic                             rst,
  input  logic                             i_game_start,
  input  logic                             i_cal_frame,
  output logic                             o_plat_req,
  input  logic                             i_plat_ack,
  input  logic [PIXELX_BIT_CNT-1:0]        i_platX,
  input  logic [PIXELY_BIT_CNT-1:0]        i_platY,
  input  logic [PLAT_HF_WIDTH_BIT_CNT-1:0] i_plat_size,
  input  logic                             i_gadget_valid,
  input  logic [PIXELX_BIT_CNT-1:0]        i_gadget_x,
  input  logic [PIXELY_BIT_CNT-1:0]        i_gadget_y,
  input  logic [GADGET_BIT_CNT-1:0]        i_gadget_type,
  output logic                             o_plat_receive_gadget,
  output logic [GADGET_BIT_CNT-1:0]        o_plat_gadget_effect,
  output logic                             o_gadget_caught,
  output logic                             o_gadget_missed,
  output logic                             o_frame_done,
  output logic                             o_link_err
);

  localparam int CNT_W = $clog2(ACK_TIMEOUT + 1);

  plat_link_state_e                 state_r;
  logic [CNT_W-1:0]                 cnt_r;
  logic [PIXELX_BIT_CNT-1:0]        plat_x_r;
  logic [PIXELY_BIT_CNT-1:0]        plat_y_r;
  logic [PLAT_HF_WIDTH_BIT_CNT-1:0] plat_size_r;
  logic                             req_r;
  logic                             recv_r;
  logic [GADGET_BIT_CNT-1:0]        effect_r;
  logic                             caught_r;
  logic                             missed_r;
  logic                             done_r;
  logic                             err_r;
  logic                             x_hit_s;
  logic                             y_hit_s;
  logic                             catch_s;
  logic                             miss_s;

  plat_overlap_chk #(
    .GADGET_HF     (GADGET_HF),
    .PLAT_HF_THICK (PLAT_HF_THICK)
  ) u_overlap (
    .gx    (i_gadget_x),
    .gy    (i_gadget_y),
    .px    (plat_x_r),
    .py    (plat_y_r),
    .size  (plat_size_r),
    .x_hit (x_hit_s),
    .y_hit (y_hit_s)
  );

  // Catch/miss decision; a catch suppresses the miss report.
  always_comb begin
    catch_s = i_gadget_valid & x_hit_s & y_hit_s;
    if (!catch_s && i_gadget_valid && (i_gadget_y >= PIXELY_BIT_CNT'(SCREEN_H))) begin
      miss_s = 1'b1;
    end else begin
      miss_s = 1'b0;
    end
  end

  // Transaction FSM with registered outputs; game start aborts but keeps geometry.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r     <= ST_IDLE;
      cnt_r       <= '0;
      plat_x_r    <= PIXELX_BIT_CNT'(320);
      plat_y_r    <= PIXELY_BIT_CNT'(0);
      plat_size_r <= PLAT_HF_WIDTH_BIT_CNT'(32);
      req_r       <= 1'b0;
      recv_r      <= 1'b0;
      effect_r    <= '0;
      caught_r    <= 1'b0;
      missed_r    <= 1'b0;
      done_r      <= 1'b0;
      err_r       <= 1'b0;
    end else if (i_game_start) begin
      state_r  <= ST_IDLE;
      cnt_r    <= '0;
      req_r    <= 1'b0;
      recv_r   <= 1'b0;
      effect_r <= '0;
      caught_r <= 1'b0;
      missed_r <= 1'b0;
      done_r   <= 1'b0;
      err_r    <= 1'b0;
    end else begin
      recv_r   <= 1'b0;
      effect_r <= '0;
      caught_r <= 1'b0;
      missed_r <= 1'b0;
      done_r   <= 1'b0;
      case (state_r)
        ST_IDLE: begin
          if (i_cal_frame) begin
            state_r <= ST_REQ;
            req_r   <= 1'b1;
            cnt_r   <= '0;
          end else begin
            state_r <= ST_IDLE;
          end
        end
        ST_REQ: begin
          if (i_plat_ack) begin
            plat_x_r    <= i_platX;
            plat_y_r    <= i_platY;
            plat_size_r <= i_plat_size;
            req_r       <= 1'b0;
            cnt_r       <= '0;
            state_r     <= ST_CHECK;
          end else if (cnt_r == CNT_W'(ACK_TIMEOUT - 1)) begin
            req_r   <= 1'b0;
            err_r   <= 1'b1;
            done_r  <= 1'b1;
            cnt_r   <= '0;
            state_r <= ST_IDLE;
          end else begin
            cnt_r <= cnt_r + CNT_W'(1);
          end
        end
        ST_CHECK: begin
          recv_r   <= catch_s;
          effect_r <= catch_s ? i_gadget_type : '0;
          caught_r <= catch_s;
          missed_r <= miss_s;
          state_r  <= ST_DELIVER;
        end
        ST_DELIVER: begin
          done_r  <= 1'b1;
          state_r <= ST_DONE;
        end
        ST_DONE: begin
          state_r <= ST_IDLE;
        end
        default: begin
          state_r <= ST_IDLE;
          req_r   <= 1'b0;
          cnt_r   <= '0;
        end
      endcase
    end
  end

  assign o_plat_req            = req_r;
  assign o_plat_receive_gadget = recv_r;
  assign o_plat_gadget_effect  = effect_r;
  assign o_gadget_caught       = caught_r;
  assign o_gadget_missed       = missed_r;
  assign o_frame_done          = done_r;
  assign o_link_err            = err_r;

endmodule

// File: tb/tb_plat_link_initiator.sv
// Self-checking bench for plat_link_initiator: directed cases plus randomized
// frames compared against an arithmetic reference model.
module tb_plat_link_initiator;
  import plat_link_pkg::*;

  logic                             clk = 1'b0;
  logic                             rst;
  logic                             i_game_start;
  logic                             i_cal_frame;
  logic                             o_plat_req;
  logic                             i_plat_ack;
  logic [PIXELX_BIT_CNT-1:0]        i_platX;
  logic [PIXELY_BIT_CNT-1:0]        i_platY;
  logic [PLAT_HF_WIDTH_BIT_CNT-1:0] i_plat_size;
  logic                             i_gadget_valid;
  logic [PIXELX_BIT_CNT-1:0]        i_gadget_x;
  logic [PIXELY_BIT_CNT-1:0]        i_gadget_y;
  logic [GADGET_BIT_CNT-1:0]        i_gadget_type;
  logic                             o_plat_receive_gadget;
  logic [GADGET_BIT_CNT-1:0]        o_plat_gadget_effect;
  logic                             o_gadget_caught;
  logic                             o_gadget_missed;
  logic                             o_frame_done;
  logic                             o_link_err;

  int vectors     = 0;
  int miscompares = 0;
  bit err_model   = 1'b0;

  plat_link_initiator dut (
    .clk                   (clk),
    .rst                   (rst),
    .i_game_start          (i_game_start),
    .i_cal_frame           (i_cal_frame),
    .o_plat_req            (o_plat_req),
    .i_plat_ack            (i_plat_ack),
    .i_platX               (i_platX),
    .i_platY               (i_platY),
    .i_plat_size           (i_plat_size),
    .i_gadget_valid        (i_gadget_valid),
    .i_gadget_x            (i_gadget_x),
    .i_gadget_y            (i_gadget_y),
    .i_gadget_type         (i_gadget_type),
    .o_plat_receive_gadget (o_plat_receive_gadget),
    .o_plat_gadget_effect  (o_plat_gadget_effect),
    .o_gadget_caught       (o_gadget_caught),
    .o_gadget_missed       (o_gadget_missed),
    .o_frame_done          (o_frame_done),
    .o_link_err            (o_link_err)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  // Reference: gadget and platform boxes intersect on both axes.
  function automatic void ref_model(input int px, input int py, input int sz, input bit gv,
                                    input int gx, input int gy, output bit caught, output bit missed);
    bit xo;
    bit yo;
    xo = (gx + 8 + sz >= px) && (gx <= px + sz + 8);
    yo = (gy + 8 + 4 >= py) && (gy <= py + 4 + 8);
    caught = gv && xo && yo;
    missed = !caught && gv && (gy >= 480);
  endfunction

  // One full frame: ack_dly >= 16 means the platform never answers.
  task automatic do_frame(input string tag, input int ack_dly, input int px, input int py,
                          input int sz, input bit gv, input int gx, input int gy,
                          input int gt, input int extra_cal);
    int  req_cnt, rx_cnt, ca_cnt, mi_cnt, done_cnt, done_at, eff;
    bit  exp_c, exp_m, tmo;
    req_cnt = 0; rx_cnt = 0; ca_cnt = 0; mi_cnt = 0; done_cnt = 0; done_at = -1; eff = -1;
    tmo = (ack_dly >= 16);
    ref_model(px, py, sz, gv, gx, gy, exp_c, exp_m);
    if (tmo) begin
      exp_c = 1'b0;
      exp_m = 1'b0;
      err_model = 1'b1;
    end
    @(negedge clk);
    i_platX        = PIXELX_BIT_CNT'(px);
    i_platY        = PIXELY_BIT_CNT'(py);
    i_plat_size    = PLAT_HF_WIDTH_BIT_CNT'(sz);
    i_gadget_valid = gv;
    i_gadget_x     = PIXELX_BIT_CNT'(gx);
    i_gadget_y     = PIXELY_BIT_CNT'(gy);
    i_gadget_type  = GADGET_BIT_CNT'(gt);
    i_cal_frame    = 1'b1;
    for (int cyc = 1; cyc <= 40; cyc++) begin
      @(negedge clk);
      i_cal_frame = (extra_cal != 0) && (cyc == extra_cal);
      if (o_plat_req) req_cnt++;
      i_plat_ack = o_plat_req && (req_cnt > ack_dly);
      if (o_plat_receive_gadget) begin
        rx_cnt++;
        eff = int'(o_plat_gadget_effect);
      end
      if (o_gadget_caught) ca_cnt++;
      if (o_gadget_missed) mi_cnt++;
      if (o_frame_done) begin
        done_cnt++;
        done_at = cyc;
      end
    end
    i_cal_frame = 1'b0;
    i_plat_ack  = 1'b0;
    check({tag, "_req_cycles"}, req_cnt, tmo ? 16 : ack_dly + 1);
    check({tag, "_done_cnt"},   done_cnt, 1);
    check({tag, "_done_at"},    done_at, tmo ? 17 : ack_dly + 4);
    check({tag, "_rx_cnt"},     rx_cnt, exp_c ? 1 : 0);
    check({tag, "_caught_cnt"}, ca_cnt, exp_c ? 1 : 0);
    check({tag, "_missed_cnt"}, mi_cnt, exp_m ? 1 : 0);
    if (exp_c) check({tag, "_effect"}, eff, gt);
    check({tag, "_link_err"},   o_link_err, err_model);
  endtask

  task automatic game_start_pulse();
    @(negedge clk);
    i_game_start = 1'b1;
    @(negedge clk);
    i_game_start = 1'b0;
    err_model = 1'b0;
  endtask

  initial begin
    int rx_seen, done_seen, req_seen;
    rst = 1'b1; i_game_start = 1'b0; i_cal_frame = 1'b0; i_plat_ack = 1'b0;
    i_platX = '0; i_platY = '0; i_plat_size = '0;
    i_gadget_valid = 1'b0; i_gadget_x = '0; i_gadget_y = '0; i_gadget_type = '0;
    repeat (3) @(negedge clk);
    check("rst_req",    o_plat_req, 0);
    check("rst_rx",     o_plat_receive_gadget, 0);
    check("rst_effect", o_plat_gadget_effect, 0);
    check("rst_caught", o_gadget_caught, 0);
    check("rst_missed", o_gadget_missed, 0);
    check("rst_done",   o_frame_done, 0);
    check("rst_err",    o_link_err, 0);
    rst = 1'b0;

    do_frame("nominal",  1, 320, 440, 32, 1'b1, 340, 436, int'(GADGET_EXPAND), 0);
    do_frame("x_miss",   1, 320, 440, 32, 1'b1, 400, 436, int'(GADGET_SHRINK), 0);
    do_frame("y_miss",   1, 320, 440, 32, 1'b1, 340, 480, int'(GADGET_FAST), 0);
    do_frame("x_edge_in",  2, 320, 440, 32, 1'b1, 280, 436, int'(GADGET_SLOW), 0);
    do_frame("x_edge_out", 2, 320, 440, 32, 1'b1, 279, 436, int'(GADGET_SLOW), 0);
    do_frame("x_edge_hi",  0, 320, 440, 32, 1'b1, 360, 452, int'(GADGET_EXPAND), 0);
    do_frame("no_gadget",  1, 320, 440, 32, 1'b0, 340, 500, int'(GADGET_EXPAND), 0);
    do_frame("overlap_cal", 1, 320, 440, 32, 1'b1, 340, 436, int'(GADGET_EXPAND), 3);
    do_frame("timeout",   99, 320, 440, 32, 1'b1, 340, 436, int'(GADGET_EXPAND), 0);
    do_frame("after_tmo", 15, 320, 440, 32, 1'b1, 340, 436, int'(GADGET_SHRINK), 0);
    game_start_pulse();
    check("gs_clears_err", o_link_err, 0);

    // Abort in REQ, then a late ack must be ignored.
    @(negedge clk); i_cal_frame = 1'b1;
    @(negedge clk); i_cal_frame = 1'b0;
    check("abort_req_up", o_plat_req, 1);
    @(negedge clk); i_game_start = 1'b1;
    @(negedge clk); i_game_start = 1'b0;
    check("abort_req_down", o_plat_req, 0);
    rx_seen = 0; done_seen = 0; req_seen = 0;
    i_plat_ack = 1'b1;
    for (int k = 0; k < 8; k++) begin
      @(negedge clk);
      if (o_plat_receive_gadget) rx_seen++;
      if (o_frame_done) done_seen++;
      if (o_plat_req) req_seen++;
    end
    i_plat_ack = 1'b0;
    check("late_ack_rx",   rx_seen, 0);
    check("late_ack_done", done_seen, 0);
    check("late_ack_req",  req_seen, 0);

    // Simultaneous game start and frame pulse: no transaction starts.
    @(negedge clk); i_cal_frame = 1'b1; i_game_start = 1'b1;
    @(negedge clk); i_cal_frame = 1'b0; i_game_start = 1'b0;
    req_seen = 0; done_seen = 0;
    for (int k = 0; k < 20; k++) begin
      @(negedge clk);
      if (o_plat_req) req_seen++;
      if (o_frame_done) done_seen++;
    end
    check("gs_wins_req",  req_seen, 0);
    check("gs_wins_done", done_seen, 0);

    for (int n = 0; n < 30; n++) begin
      int px, py, sz, gx, gy, span;
      px   = int'($urandom_range(40, 600));
      py   = int'($urandom_range(100, 470));
      sz   = int'($urandom_range(0, 63));
      span = sz + 20;
      gx   = px + int'($urandom_range(0, 2 * span)) - span;
      if (gx < 0) gx = 0;
      if ($urandom_range(0, 3) == 0) gy = int'($urandom_range(480, 600));
      else gy = py + int'($urandom_range(0, 40)) - 20;
      do_frame("rand", int'($urandom_range(0, 6)), px, py, sz, ($urandom_range(0, 3) != 0),
               gx, gy, int'($urandom_range(1, 7)), 0);
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
